alu_share_arbiter: RTL

Two-requester round-robin arbiter that shares one combinational ALU in the CPU datapath between two clients, e.g. the execute stage and an address/branch-compare helper. Requests use a valid/ready handshake and are registered into one issue stage that drives the ALU. The ALU result and zero flag are captured into a one-entry response register per requester, and each requester may have at most one operation outstanding.

---
 rtl/alu_share_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU through a single registered issue stage.
// Build macro ALU_ARB_FIXED_PRIO_EN: requester 0 wins every tie instead of round-robin.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp0_zero,
  output logic             rsp1_zero,
  output logic [CNT_W-1:0] contention_cnt
);

  logic [1:0]       r_busy;
  logic [1:0]       r_rsp_valid;
  logic             r_last;
  logic             r_iss_valid;
  logic             r_iss_id;
  logic [WIDTH-1:0] r_alu_A;
  logic [WIDTH-1:0] r_alu_B;
  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_rsp0_result;
  logic [WIDTH-1:0] r_rsp1_result;
  logic             r_rsp0_zero;
  logic             r_rsp1_zero;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0] w_rsp_hs;
  logic [1:0] w_elig;
  logic [1:0] w_cand;
  logic [1:0] w_grant;
  logic [1:0] w_land;
  logic       w_stall;

  // A requester whose response drains this cycle may already issue its next op.
  assign w_rsp_hs = r_rsp_valid & rsp_ready;
  assign w_elig   = ~r_busy | w_rsp_hs;
  assign w_cand   = req_valid & w_elig;
  assign w_land   = {r_iss_valid & r_iss_id, r_iss_valid & ~r_iss_id};
  assign w_stall  = (w_cand[0] & w_grant[1]) | (w_cand[1] & w_grant[0]);

  // Grant selection among eligible valid requesters
  always_comb begin
    w_grant = 2'b00;
    if (rst) begin
      w_grant = 2'b00;
    end else begin
      case (w_cand)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
        2'b11:   w_grant = 2'b01;
`else
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
`endif
        default: w_grant = 2'b00;
      endcase
    end
  end

  // Issue register: operands are only loaded on accept so the ALU inputs stay quiet when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_A     <= '0;
      r_alu_B     <= '0;
      r_alu_op    <= 4'd0;
      r_iss_valid <= 1'b0;
      r_iss_id    <= 1'b0;
      r_last      <= 1'b1;
    end else begin
      if (w_grant[0]) begin
        r_alu_A  <= req0_A;
        r_alu_B  <= req0_B;
        r_alu_op <= req0_op;
        r_iss_id <= 1'b0;
        r_last   <= 1'b0;
      end else if (w_grant[1]) begin
        r_alu_A  <= req1_A;
        r_alu_B  <= req1_B;
        r_alu_op <= req1_op;
        r_iss_id <= 1'b1;
        r_last   <= 1'b1;
      end
      r_iss_valid <= |w_grant;
    end
  end

  // Per-requester busy tracking and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy        <= 2'b00;
      r_rsp_valid   <= 2'b00;
      r_rsp0_result <= '0;
      r_rsp1_result <= '0;
      r_rsp0_zero   <= 1'b0;
      r_rsp1_zero   <= 1'b0;
    end else begin
      r_busy      <= w_grant | (r_busy & ~w_rsp_hs);
      r_rsp_valid <= w_land | (r_rsp_valid & ~rsp_ready);
      if (w_land[0]) begin
        r_rsp0_result <= alu_result;
        r_rsp0_zero   <= alu_zero;
      end
      if (w_land[1]) begin
        r_rsp1_result <= alu_result;
        r_rsp1_zero   <= alu_zero;
      end
    end
  end

  // Saturating count of cycles where an eligible requester lost to the other
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign req_ready      = w_grant;
  assign alu_A          = r_alu_A;
  assign alu_B          = r_alu_B;
  assign alu_op         = r_alu_op;
  assign rsp_valid      = r_rsp_valid;
  assign rsp0_result    = r_rsp0_result;
  assign rsp1_result    = r_rsp1_result;
  assign rsp0_zero      = r_rsp0_zero;
  assign rsp1_zero      = r_rsp1_zero;
  assign contention_cnt = r_cnt;

endmodule
